div: RTL and testbench
======================

// Module: div
// PURPOSE
//  Iterative restoring integer divider; the inverse-operation companion of the sequential multiplier.
//  Accepts dividend/divisor on a start pulse and iterates STAGE_BITS quotient bits per cycle.
//  Presents quotient/remainder with a level done flag, using the same start/done handshake as mult.
//  Sits beside mult in the execute stage; both units share the same bench style.
// PARAMETERS
//  XLEN        64  operand/result width in bits
//  STAGE_BITS  1   quotient bits resolved per cycle; legal values 1,2,4,8 (XLEN % STAGE_BITS == 0)
// PORTS
//  clock      in   1     single clock; all state updates on posedge
//  reset      in   1     synchronous, active-high
//  start      in   1     sampled on posedge; launches a divide with current operands
//  dividend   in   XLEN  numerator, captured on the start edge
//  divisor    in   XLEN  denominator, captured on the start edge
//  quotient   out  XLEN  valid while done=1
//  remainder  out  XLEN  valid while done=1
//  done       out  1     registered level; high from completion until the next start edge
// BEHAVIOUR
//  - Reset (sync, active-high) wins over start. Values: state=IDLE, done=0, quotient=0, remainder=0, counter=0.
//  - FSM states: IDLE, BUSY, DONE.
//    - IDLE/DONE + start -> BUSY.
//    - BUSY -> DONE when the counter reaches N = XLEN/STAGE_BITS.
//    - BUSY + start -> BUSY: abort; reload the new operands and restart the counter.
//  - Edge 0 samples start:
//    - Latch operands; remainder accumulator=0; counter=0; done drops to 0 after this edge.
//  - Edges 1..N: each edge performs STAGE_BITS restoring steps, MSB first.
//    - Step: shift {rem,q} left 1; if rem >= divisor, subtract and set q LSB.
//  - Edge N: last step completes; state=DONE; done=1 visible after edge N.
//    - Latency is fixed at N cycles for every operand value, including a zero divisor.
//  - Outputs hold while in DONE; operand inputs may change freely after edge 0.
//  - Remainder accumulator is XLEN+1 bits wide for the compare; outputs are truncated to XLEN.
//  - Divide by zero: quotient = all ones, remainder = dividend (falls out of the restoring algorithm).
//  - start held high continuously: the unit restarts every cycle and never completes (legal, documented).
// CONFIGURATION
//  DIV_SIGNED_EN defined:
//  - Adds input port is_signed (1 bit, captured on the start edge).
//  - When is_signed=1, operands are two's-complement. The core divides magnitudes, then:
//    - quotient sign = sign(dividend) ^ sign(divisor);
//    - remainder sign = sign(dividend).
//  - Sign fix-up is applied combinationally on the DONE outputs; latency is unchanged.
//  - Divisor 0: quotient = all ones, remainder = dividend (sign fix-up bypassed).
//  - Overflow MIN / -1: quotient = MIN, remainder = 0.
//  DIV_SIGNED_EN undefined: the is_signed port is absent; unsigned only.
// STRUCTURE
//  Package div_pkg:
//  - typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
//  - localparam default XLEN;
//  - typedef logic [XLEN-1:0] xlen_t.
//  Sub-module div_stage (combinational, one restoring step):
//  - in: rem, q, divisor. out: rem_next, q_next.
//  - div generates STAGE_BITS chained instances.
//  Top: FSM, iteration counter, operand/accumulator registers, optional sign fix-up.
// TESTING
//  Check every cycle: done -> (quotient === dividend/divisor) && (remainder === dividend%divisor).
//  1. Reset held 2 cycles, then start with 100/7 -> done high after exactly N edges; q=14, r=2.
//  2. 64'hFFFF_FFFF_FFFF_FFFF / 1 -> q=all ones, r=0.
//     3 / 64'hFFFF_FFFF_FFFF_FFFF -> q=0, r=3.
//  3. 12345 / 0 -> q=64'hFFFF_FFFF_FFFF_FFFF, r=12345; latency is still N.
//  4. Start 1000/3; re-pulse start N/2 cycles later with 81/9 -> done once, N edges after the second start; q=9, r=0.
//  5. Reset asserted mid-BUSY -> next edge: done=0, q=0, r=0. A later start of 50/5 yields q=10, r=0.
//  6. 16 random {$random,$random} pairs, checked against / and %.
//     With DIV_SIGNED_EN: -7/2 -> q=-3, r=-1; MIN/-1 -> q=MIN, r=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package div_pkg;

    localparam int unsigned XLEN = 64;

    typedef logic [XLEN-1:0] xlen_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_if.sv
// Start/done handshake bundle between the execute stage and the divider.
// Optional feature macro: DIV_SIGNED_EN adds the is_signed request bit.
interface div_if
    import div_pkg::*;
#(
    parameter int unsigned XLEN = div_pkg::XLEN
);

    logic            start;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic            is_signed;
`endif
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            done;

`ifdef DIV_SIGNED_EN
    modport master (
        output start, dividend, divisor, is_signed,
        input  quotient, remainder, done
    );

    modport slave (
        input  start, dividend, divisor, is_signed,
        output quotient, remainder, done
    );
`else
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done
    );
`endif

endinterface

// File: rtl/div_stage.sv
// One restoring division step: shift {rem,q} left, subtract divisor if it fits.
module div_stage
    import div_pkg::*;
#(
    parameter int unsigned XLEN = div_pkg::XLEN
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] q_next
);

    localparam int unsigned RW = XLEN + 1;

    logic [XLEN:0] shifted;
    logic [XLEN:0] dvs_ext;

    // Compare the shifted partial remainder against the divisor and restore if smaller
    always_comb begin
        shifted  = RW'({rem, q[XLEN-1]});
        dvs_ext  = {1'b0, divisor};
        rem_next = shifted;
        q_next   = {q[XLEN-2:0], 1'b0};
        if (shifted >= dvs_ext) begin
            rem_next  = shifted - dvs_ext;
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div.sv
// Iterative restoring divider, STAGE_BITS quotient bits per cycle, start/done handshake.
// Optional feature macro: DIV_SIGNED_EN enables two's-complement operands via is_signed.
module div
    import div_pkg::*;
#(
    parameter int unsigned XLEN       = div_pkg::XLEN,
    parameter int unsigned STAGE_BITS = 1
) (
    input logic  clock,
    input logic  reset,
    div_if.slave bus
);

    localparam int unsigned STEPS = XLEN / STAGE_BITS;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    // Elaboration-time guard on the stage width
    if (!(STAGE_BITS == 1 || STAGE_BITS == 2 || STAGE_BITS == 4 || STAGE_BITS == 8)
        || (XLEN % STAGE_BITS) != 0) begin : g_bad_cfg
        $error("div: STAGE_BITS must be 1, 2, 4 or 8 and divide XLEN");
    end

    div_state_t      state;
    div_state_t      state_next;
    logic            load_c;
    logic            step_c;
    logic            done_d;

    logic [XLEN-1:0] q_reg;
    logic [XLEN:0]   rem_reg;
    logic [XLEN-1:0] dvs_reg;
    logic [CNT_W-1:0] count;
    logic            done_reg;

    logic [XLEN-1:0] dvd_load;
    logic [XLEN-1:0] dvs_load;

    logic [XLEN:0]   rem_ch [STAGE_BITS+1];
    logic [XLEN-1:0] q_ch   [STAGE_BITS+1];

`ifdef DIV_SIGNED_EN
    logic neg_dvd;
    logic neg_dvs;
    logic neg_q;
    logic neg_r;

    // The core always divides magnitudes; signs are reapplied on the outputs
    always_comb begin
        neg_dvd  = bus.is_signed & bus.dividend[XLEN-1];
        neg_dvs  = bus.is_signed & bus.divisor[XLEN-1];
        dvd_load = neg_dvd ? -bus.dividend : bus.dividend;
        dvs_load = neg_dvs ? -bus.divisor  : bus.divisor;
    end
`else
    // Unsigned operands feed the core unchanged
    always_comb begin
        dvd_load = bus.dividend;
        dvs_load = bus.divisor;
    end
`endif

    // Chain of restoring steps evaluated within one cycle
    assign rem_ch[0] = rem_reg;
    assign q_ch[0]   = q_reg;

    for (genvar i = 0; i < STAGE_BITS; i++) begin : g_stage
        div_stage #(
            .XLEN (XLEN)
        ) u_stage (
            .rem      (rem_ch[i]),
            .q        (q_ch[i]),
            .divisor  (dvs_reg),
            .rem_next (rem_ch[i+1]),
            .q_next   (q_ch[i+1])
        );
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start always (re)launches; BUSY finishes on its last step
    always_comb begin
        state_next = state;
        unique case (state)
            DIV_IDLE, DIV_DONE: begin
                if (bus.start) begin
                    state_next = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (bus.start) begin
                    state_next = DIV_BUSY;
                end else if (count == CNT_W'(STEPS - 1)) begin
                    state_next = DIV_DONE;
                end
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    // FSM outputs: operand load, iteration step and the next done level
    always_comb begin
        load_c = 1'b0;
        step_c = 1'b0;
        done_d = 1'b0;
        unique case (state)
            DIV_IDLE, DIV_DONE: begin
                load_c = bus.start;
            end
            DIV_BUSY: begin
                load_c = bus.start;
                step_c = ~bus.start;
            end
            default: ;
        endcase
        done_d = (state_next == DIV_DONE);
    end

    // Operand, accumulator, counter and done registers
    always_ff @(posedge clock) begin
        if (reset) begin
            q_reg    <= '0;
            rem_reg  <= '0;
            dvs_reg  <= '0;
            count    <= '0;
            done_reg <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done_reg <= done_d;
            if (load_c) begin
                q_reg   <= dvd_load;
                rem_reg <= '0;
                dvs_reg <= dvs_load;
                count   <= '0;
`ifdef DIV_SIGNED_EN
                neg_q   <= neg_dvd ^ neg_dvs;
                neg_r   <= neg_dvd;
`endif
            end else if (step_c) begin
                q_reg   <= q_ch[STAGE_BITS];
                rem_reg <= rem_ch[STAGE_BITS];
                count   <= count + CNT_W'(1);
            end
        end
    end

    assign bus.done = done_reg;

`ifdef DIV_SIGNED_EN
    // Sign fix-up; a zero divisor keeps the all-ones quotient unnegated
    always_comb begin
        bus.quotient  = (neg_q && (dvs_reg != '0)) ? -q_reg : q_reg;
        bus.remainder = neg_r ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];
    end
`else
    // Results come straight from the working registers
    always_comb begin
        bus.quotient  = q_reg;
        bus.remainder = rem_reg[XLEN-1:0];
    end
`endif

endmodule

// File: tb/tb_div.sv
// Directed and random checks for the restoring divider (handshake, latency, corner cases).
module tb_div;
    import div_pkg::*;

    localparam int unsigned STAGE_BITS = 1;
    localparam int unsigned N          = XLEN / STAGE_BITS;

    logic  clock = 1'b0;
    logic  reset;
    int    n_checks = 0;
    int    n_pass   = 0;
    xlen_t exp_q;
    xlen_t exp_r;
    logic  mon_en = 1'b0;
`ifdef DIV_SIGNED_EN
    logic  sgn_sel = 1'b0;
`endif

    div_if #(.XLEN(XLEN)) bus ();

    div #(
        .XLEN       (XLEN),
        .STAGE_BITS (STAGE_BITS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Whenever done is held, the results must match the current expectation
    always @(negedge clock) begin
        if (mon_en && !reset && bus.done === 1'b1 && !bus.start) begin
            check("mon_q", bus.quotient, exp_q);
            check("mon_r", bus.remainder, exp_r);
        end
    end

    task automatic launch(input xlen_t a, input xlen_t b, input xlen_t eq, input xlen_t er);
        @(posedge clock);
        #1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef DIV_SIGNED_EN
        bus.is_signed = sgn_sel;
`endif
        exp_q     = eq;
        exp_r     = er;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
    endtask

    task automatic do_div(input string tag, input xlen_t a, input xlen_t b,
                          input xlen_t eq, input xlen_t er);
        int cycles;
        launch(a, b, eq, er);
        check({tag, "_drop"}, 64'(bus.done), 64'd0);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles <= int'(N) + 4) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        check({tag, "_lat"}, 64'(cycles), 64'(N));
        check({tag, "_q"}, bus.quotient, eq);
        check({tag, "_r"}, bus.remainder, er);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        xlen_t a;
        xlen_t b;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef DIV_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        exp_q = '0;
        exp_r = '0;

        // 1. reset state, then a basic divide
        repeat (2) @(posedge clock);
        #1;
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_q", bus.quotient, 64'd0);
        check("rst_r", bus.remainder, 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        do_div("t1", 64'd100, 64'd7, 64'd14, 64'd2);

        // 2. extreme operands
        do_div("max_by1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        do_div("small_by_max", 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd3);

        // 3. divide by zero, same latency
        do_div("by0", 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12345);

        // 4. abort mid-flight with new operands
        launch(64'd1000, 64'd3, 64'd333, 64'd1);
        repeat (N / 2 - 2) @(posedge clock);
        #1;
        check("abort_busy", 64'(bus.done), 64'd0);
        do_div("abort", 64'd81, 64'd9, 64'd9, 64'd0);

        // 5. reset while busy clears everything
        launch(64'd1000, 64'd3, 64'd333, 64'd1);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_q", bus.quotient, 64'd0);
        check("mid_rst_r", bus.remainder, 64'd0);
        reset = 1'b0;
        do_div("post_rst", 64'd50, 64'd5, 64'd10, 64'd0);

        // 6. random operands against the language operators
        for (int i = 0; i < 16; i++) begin
            a = {$urandom(), $urandom()};
            if (i % 2 == 0) begin
                b = {$urandom(), $urandom()};
            end else begin
                b = {32'd0, $urandom()};
            end
            if (b == '0) begin
                b = 64'd1;
            end
            do_div("rnd", a, b, a / b, a % b);
        end

`ifdef DIV_SIGNED_EN
        sgn_sel = 1'b1;
        do_div("s_neg7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        do_div("s_min_m1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'd0);
        do_div("s_neg_by0", 64'hFFFF_FFFF_FFFF_FFF9, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9);
        sgn_sel = 1'b0;
`endif

        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
